// File: rtl/conv2_window_buf.sv
// 5x5 per-channel window generator for the second conv layer: buffers FILTER_SIZE-1 rows plus
// FILTER_SIZE pixels per channel. Optional frame_done pulse via `define CONV2_WIN_FRAME_DONE_EN.

module conv2_win_lane #(
    parameter int WIDTH       = 12,
    parameter int FILTER_SIZE = 5,
    parameter int DATA_BITS   = 12
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     shift_en,
    input  logic                                     emit,
    input  logic [DATA_BITS-1:0]                     din,
    output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] win
);
    localparam int D = WIDTH*(FILTER_SIZE-1) + FILTER_SIZE;

    // Chain index 0 is the incoming sample itself, so only D-1 stages are stored.
    logic [DATA_BITS-1:0] chain [D-1];
    logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] win_next;

    always_ff @(posedge clk) begin
        if (shift_en) begin
            chain[0] <= din;
            for (int k = 1; k < D-1; k++) chain[k] <= chain[k-1];
        end
    end

    for (genvar gi = 0; gi < FILTER_SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < FILTER_SIZE; gj++) begin : g_col
            localparam int IDX = (FILTER_SIZE-1-gi)*WIDTH + (FILTER_SIZE-1-gj);
            if (IDX == 0) begin : g_new
                assign win_next[(gi*FILTER_SIZE+gj)*DATA_BITS +: DATA_BITS] = din;
            end else begin : g_old
                assign win_next[(gi*FILTER_SIZE+gj)*DATA_BITS +: DATA_BITS] = chain[IDX-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    win <= '0;
        else if (emit) win <= win_next;
    end
endmodule

module conv2_window_buf #(
    parameter int WIDTH       = 12,
    parameter int HEIGHT      = 12,
    parameter int FILTER_SIZE = 5,
    parameter int DATA_BITS   = 12
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         valid_in,
    input  logic [DATA_BITS-1:0]                         data_in_1,
    input  logic [DATA_BITS-1:0]                         data_in_2,
    input  logic [DATA_BITS-1:0]                         data_in_3,
    output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] data_out_1,
    output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] data_out_2,
    output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] data_out_3,
    output logic                                         valid_out
`ifdef CONV2_WIN_FRAME_DONE_EN
    ,
    output logic                                         frame_done
`endif
);
    localparam int NUM_CH   = 3;
    localparam int WIN_BITS = FILTER_SIZE*FILTER_SIZE*DATA_BITS;
    localparam int CW       = $clog2(WIDTH);
    localparam int RW       = $clog2(HEIGHT);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last, row_last, emit;

    logic [NUM_CH-1:0][DATA_BITS-1:0] din;
    logic [NUM_CH-1:0][WIN_BITS-1:0]  win;

    assign col_last = (col == CW'(WIDTH-1));
    assign row_last = (row == RW'(HEIGHT-1));
    // Row guard also keeps windows from spanning frames or using pre-reset chain data.
    assign emit = valid_in && (row >= RW'(FILTER_SIZE-1)) && (col >= CW'(FILTER_SIZE-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_out <= 1'b0;
        else        valid_out <= emit;
    end

`ifdef CONV2_WIN_FRAME_DONE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= emit && row_last && col_last;
    end
`endif

    assign din = {data_in_3, data_in_2, data_in_1};

    conv2_win_lane #(
        .WIDTH(WIDTH), .FILTER_SIZE(FILTER_SIZE), .DATA_BITS(DATA_BITS)
    ) u_lane [NUM_CH-1:0] (
        .clk(clk), .rst_n(rst_n), .shift_en(valid_in), .emit(emit), .din(din), .win(win)
    );

    assign data_out_1 = win[0];
    assign data_out_2 = win[1];
    assign data_out_3 = win[2];
endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf: continuous, gapped, back-to-back and mid-frame reset.
`timescale 1ns/1ps
module tb_conv2_window_buf;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in;
    logic [11:0]  data_in_1, data_in_2, data_in_3;
    logic [299:0] d1, d2, d3;
    logic         vo;
`ifdef CONV2_WIN_FRAME_DONE_EN
    logic         fd;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [299:0] h1, h2, h3;

    always #5 clk = ~clk;

    conv2_window_buf dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
        .data_out_1(d1), .data_out_2(d2), .data_out_3(d3),
        .valid_out(vo)
`ifdef CONV2_WIN_FRAME_DONE_EN
        , .frame_done(fd)
`endif
    );

    task automatic chk(input string tag, input logic [299:0] got, input logic [299:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", tag, got, exp);
    endtask

    function automatic int pix(input int ch, input int r, input int c, input int base);
        return base + ch*200 + r*12 + c;
    endfunction

    function automatic logic [299:0] exp_win(input int ch, input int r, input int c, input int base);
        logic [299:0] w = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                w[(i*5+j)*12 +: 12] = 12'(pix(ch, r-4+i, c-4+j, base));
        return w;
    endfunction

    function automatic logic [11:0] elem(input logic [299:0] w, input int i, input int j);
        return w[(i*5+j)*12 +: 12];
    endfunction

    task automatic push(input logic v, input int a, input int b, input int c);
        @(negedge clk);
        valid_in  = v;
        data_in_1 = 12'(a);
        data_in_2 = 12'(b);
        data_in_3 = 12'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int base, input bit gap);
        int npulse = 0;
        int first  = -1;
        int idx    = 0;
        bit ev;
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 12; c++) begin
                push(1'b1, pix(0,r,c,base), pix(1,r,c,base), pix(2,r,c,base));
                ev = (r >= 4) && (c >= 4);
                chk($sformatf("vo_r%0dc%0d", r, c), 300'(vo), 300'(ev));
                if (vo) begin
                    npulse++;
                    if (first < 0) first = idx;
                end
`ifdef CONV2_WIN_FRAME_DONE_EN
                chk($sformatf("fd_r%0dc%0d", r, c), 300'(fd), 300'(ev && r == 11 && c == 11));
`endif
                if (ev) begin
                    chk($sformatf("win1_r%0dc%0d", r, c), d1, exp_win(0, r, c, base));
                    chk($sformatf("win2_r%0dc%0d", r, c), d2, exp_win(1, r, c, base));
                    chk($sformatf("win3_r%0dc%0d", r, c), d3, exp_win(2, r, c, base));
                    h1 = exp_win(0, r, c, base);
                    h2 = exp_win(1, r, c, base);
                    h3 = exp_win(2, r, c, base);
                end else begin
                    chk($sformatf("hold1_r%0dc%0d", r, c), d1, h1);
                end
                // Hand-computed corner elements
                if (r == 4 && c == 4) begin
                    chk("first_e00", 300'(elem(d1,0,0)), 300'(base + 0));
                    chk("first_e04", 300'(elem(d1,0,4)), 300'(base + 4));
                    chk("first_e40", 300'(elem(d1,4,0)), 300'(base + 48));
                    chk("first_e44", 300'(elem(d1,4,4)), 300'(base + 52));
                    chk("first_ch3_e44", 300'(elem(d3,4,4)), 300'(base + 452));
                end
                if (r == 5 && c == 3) chk("r5c3_novalid", 300'(vo), 300'(0));
                if (r == 5 && c == 4) begin
                    chk("r5c4_e00", 300'(elem(d1,0,0)), 300'(base + 12));
                    chk("r5c4_e44", 300'(elem(d1,4,4)), 300'(base + 64));
                end
                if (r == 11 && c == 11) begin
                    chk("last_e00", 300'(elem(d1,0,0)), 300'(base + 91));
                    chk("last_e44", 300'(elem(d1,4,4)), 300'(base + 143));
                end
                idx++;
                if (gap) begin
                    push(1'b0, 12'hfff, 12'hfff, 12'hfff);
                    chk($sformatf("gap_vo_r%0dc%0d", r, c), 300'(vo), 300'(0));
                    chk($sformatf("gap_hold_r%0dc%0d", r, c), d1, h1);
`ifdef CONV2_WIN_FRAME_DONE_EN
                    chk("gap_fd", 300'(fd), 300'(0));
`endif
                end
            end
        end
        chk("npulse", 300'(npulse), 300'(64));
        chk("first_idx", 300'(first), 300'(52));
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0;
        data_in_1 = '0; data_in_2 = '0; data_in_3 = '0;
        h1 = '0; h2 = '0; h3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vo", 300'(vo), 300'(0));
        chk("rst_d1", d1, 300'(0));
        chk("rst_d2", d2, 300'(0));
        chk("rst_d3", d3, 300'(0));
`ifdef CONV2_WIN_FRAME_DONE_EN
        chk("rst_fd", 300'(fd), 300'(0));
`endif
        @(negedge clk) rst_n = 1'b1;

        run_frame(0, 1'b0);
        run_frame(1000, 1'b0);
        run_frame(0, 1'b1);

        // 70 pixels then asynchronous reset; pixel 69 is (5,9) and emits
        for (int k = 0; k < 70; k++)
            push(1'b1, pix(0,k/12,k%12,0), pix(1,k/12,k%12,0), pix(2,k/12,k%12,0));
        chk("pre_rst_vo", 300'(vo), 300'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vo", 300'(vo), 300'(0));
        chk("mid_rst_d1", d1, 300'(0));
        chk("mid_rst_d2", d2, 300'(0));
        chk("mid_rst_d3", d3, 300'(0));
        h1 = '0; h2 = '0; h3 = '0;
        @(negedge clk) rst_n = 1'b1;
        valid_in = 1'b0;
        run_frame(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv2_window_buf.md
# conv2_window_buf

Window generator between `maxpool_relu_1` and the second convolution layer. It accepts the 12×12, 3-channel pooled/ReLU raster stream one pixel per `valid_in`. It buffers the last FILTER_SIZE-1 rows plus FILTER_SIZE pixels per channel and emits a complete 5×5 window for each channel whenever the newest pixel closes a valid window position. A frame yields 8×8 = 64 windows.

## Interface
- `WIDTH`, default 12: pixels per input row.
- `HEIGHT`, default 12: rows per input frame.
- `FILTER_SIZE`, default 5: window edge length.
- `DATA_BITS`, default 12: bits per channel sample.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous reset, active low.
- `valid_in`  in  1  one pixel (all 3 channels) presented this cycle.
- `data_in_1`, `data_in_2`, `data_in_3`  in  DATA_BITS each  channel samples; connect to the `max_value_*` outputs.
- `data_out_1`, `data_out_2`, `data_out_3`  out  FILTER_SIZE²·DATA_BITS each (300)  packed window per channel.
- `valid_out`  out  1  window on `data_out_*` is valid this cycle.
- `frame_done`  out  1  present only with `CONV2_WIN_FRAME_DONE_EN`; see Configuration.

## Operation
- Each channel has a shift chain of depth D = WIDTH·(FILTER_SIZE-1)+FILTER_SIZE (53). On `valid_in`=1, every chain shifts by one and the new sample enters at index 0. With `valid_in`=0, nothing shifts.
- Counters `col` (0..WIDTH-1) and `row` (0..HEIGHT-1) give the position of the pixel being accepted.
  - On each accepted pixel, `col` increments.
  - At `col`=WIDTH-1, `col`→0 and `row` increments.
  - At (HEIGHT-1, WIDTH-1), both counters →0. The next accepted pixel is (0,0) of the next frame.
- A window is emitted when the accepted pixel has `row`≥FILTER_SIZE-1 and `col`≥FILTER_SIZE-1.
  - Window element (i,j), with i,j in 0..4, is the pixel at (row-4+i, col-4+j).
  - That pixel is chain index (4-i)·WIDTH+(4-j) after the shift, counting the new pixel.
- Packing: element (i,j) occupies bits [(i·FILTER_SIZE+j)·DATA_BITS +: DATA_BITS]. Element (0,0) is at the LSBs.
- Samples pass through unmodified; there is no arithmetic or sign handling.
- Positions with `col`<4 wrap across row boundaries in the chain. These positions never emit.
- Rows 0..3 of a new frame never emit, so windows never span frames.

## Timing
- Latency is 1 cycle: `valid_out` and `data_out_*` are registered. They update on the clock edge that accepts the closing pixel.
- `valid_out` is a single-cycle pulse per window and is 0 in every cycle where no window closes, including `valid_in`=0 cycles.
- `data_out_*` holds its last value when `valid_out`=0.
- There is no backpressure; the consumer must accept every `valid_out` pulse.
- Back-to-back `valid_in` gives up to 8 consecutive `valid_out` pulses per eligible row. Gaps in `valid_in` only stretch the timing.
- Reset values: `valid_out`=0, `data_out_*`=0, `frame_done`=0, `row`=`col`=0. Chain contents are don't-care.
- Reset asserted mid-frame:
  - Outputs clear immediately (asynchronously).
  - The next accepted pixel after release is (0,0).
  - No window uses pre-reset data for emission decisions, because the row guard covers this.

## Configuration
- `CONV2_WIN_FRAME_DONE_EN` defined:
  - Adds output `frame_done` (1 bit, reset 0).
  - `frame_done` pulses high for one cycle together with the `valid_out` of the frame's last window, at position (11,11).
- Not defined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- **Single frame, continuous:** drive ch1=r·12+c, ch2=200+r·12+c, ch3=400+r·12+c, `valid_in`=1 for 144 cycles.
  - First `valid_out` follows input #52 (position 4,4).
  - Window ch1 elem(0,0)=0, elem(0,4)=4, elem(4,0)=48, elem(4,4)=52; ch3 elem(4,4)=452.
  - Exactly 64 pulses in total.
- **Row-edge check:** at input (5,3) there is no `valid_out`. At (5,4), ch1 elems (0,0)=12 and (4,4)=64; at (11,11), ch1 elem(0,0)=91 and elem(4,4)=143.
- **Gapped input:** same frame with `valid_in` toggling 1/0. The same 64 windows and values appear, `valid_out` is never high in the cycle after a `valid_in`=0 cycle, and the window count is unchanged.
- **Back-to-back frames:** two frames with no gap, where frame 2 = frame 1 + 1000.
  - No `valid_out` during frame 2 rows 0..3.
  - Frame 2 first window elem(0,0)=1000.
- **Reset mid-frame:** assert `rst_n`=0 after 70 pixels. `valid_out`/`data_out_*` go to 0 immediately. After release, a fresh full frame reproduces the first scenario's results exactly.
- **Frame-done (macro defined):** `frame_done` pulses exactly once per frame, coincident with the 64th `valid_out`. It stays 0 during the reset and gap scenarios except at that point.
